// File: rtl/div3_stream_scheduler_pkg.sv
// Shared encodings and the mod-3 step function for the divisibility scheduler.
package div3_stream_scheduler_pkg;

  localparam int unsigned RES_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [RES_W-1:0] R0 = 2'd0;
  localparam logic [RES_W-1:0] R1 = 2'd1;
  localparam logic [RES_W-1:0] R2 = 2'd2;

  // Residue after appending bit b below a value whose residue is r: (2r + b) mod 3.
  function automatic logic [RES_W-1:0] mod3_step(input logic [RES_W-1:0] r, input logic b);
    logic [RES_W-1:0] nxt;
    case (r)
      R0:      nxt = b ? R1 : R0;
      R1:      nxt = b ? R0 : R2;
      R2:      nxt = b ? R2 : R1;
      default: nxt = R0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/div3_stream_scheduler_mod3.sv
// Serial MSB-first mod-3 residue tracker with synchronous clear.
module mod3_residue_fsm
  import div3_stream_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [RES_W-1:0] residue
);

  logic [RES_W-1:0] r_residue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_residue <= R0;
    end else if (clr) begin
      r_residue <= R0;
    end else if (bit_valid) begin
      r_residue <= mod3_step(r_residue, bit_in);
    end
  end

  assign residue = r_residue;

endmodule

// File: rtl/div3_stream_scheduler.sv
// Round-robin scheduler sharing one serial mod-3 residue datapath between NREQ producers.
module div3_stream_scheduler
  import div3_stream_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req,
  input  logic [NREQ*WIDTH-1:0]                 data,
  output logic [NREQ-1:0]                       gnt,
  output logic                                  busy,
  output logic                                  done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
  output logic [RES_W-1:0]                      residue,
  output logic                                  divisible
);

  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [IDW-1:0]   r_rr;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic             r_done;
  logic [IDW-1:0]   r_done_id;
  logic [RES_W-1:0] r_residue;
  logic             r_divisible;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic             w_capture;
  logic [RES_W-1:0] w_res;
  logic [RES_W-1:0] w_res_next;
  logic [WIDTH-1:0] w_words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign w_words[g] = data[g*WIDTH +: WIDTH];
  end

  // First requester above the last winner, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!w_found && req[IDW'((32'(r_rr) + k) % NREQ)]) begin
        w_found  = 1'b1;
        w_winner = IDW'((32'(r_rr) + k) % NREQ);
      end
    end
  end

  assign w_capture  = (r_state == ST_IDLE) && w_found;
  assign w_res_next = mod3_step(w_res, r_shift[WIDTH-1]);

  mod3_residue_fsm u_mod3 (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_capture),
    .bit_valid (r_state == ST_SHIFT),
    .bit_in    (r_shift[WIDTH-1]),
    .residue   (w_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= IDW'(NREQ - 1);
      r_shift     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_residue   <= '0;
      r_divisible <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_shift <= w_words[w_winner];
            r_cnt   <= CNT_W'(WIDTH);
            r_rr    <= w_winner;
            r_gnt   <= NREQ'(1) << w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          // Last bit: publish the result so it is visible in the REPORT cycle.
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_REPORT;
            r_done      <= 1'b1;
            r_done_id   <= r_rr;
            r_residue   <= w_res_next;
            r_divisible <= (w_res_next == R0);
          end
        end
        ST_REPORT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign residue   = r_residue;
  assign divisible = r_divisible;

endmodule

// File: tb/tb_div3_stream_scheduler.sv
// Directed bench for div3_stream_scheduler with hand-computed residues and grant order.
module tb_div3_stream_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [31:0] data;
  logic [3:0] gnt;
  logic       busy;
  logic       done;
  logic [1:0] done_id;
  logic [1:0] residue;
  logic       divisible;

  logic [7:0] words [4];
  int n_checks;
  int n_errors;

  always_comb data = {words[3], words[2], words[1], words[0]};

  div3_stream_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .residue   (residue),
    .divisible (divisible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 4'd0 && n < budget);
    chk({tag, "_gnt_seen"}, 32'(gnt != 4'd0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < budget);
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Single transaction from IDLE: checks grant, latency, result and return to IDLE.
  task automatic run_word(input string tag, input int idx, input logic [7:0] w,
                          input logic [1:0] exp_res);
    words[idx] = w;
    req = 4'b0001 << idx;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << idx));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = 4'd0;
    repeat (7) tick();
    chk({tag, "_early_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_id"}, 32'(done_id), 32'(idx));
    chk({tag, "_res"}, 32'(residue), 32'(exp_res));
    chk({tag, "_div"}, 32'(divisible), 32'(exp_res == 2'd0));
    chk({tag, "_busy_rep"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int gnt_or;
    int done_cnt;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) words[i] = 8'hA5;

    // Reset dominates pending requests
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(residue), 32'd0);
    req = 4'd0;
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_word("w6", 0, 8'd6, 2'd0);
    run_word("w7", 1, 8'd7, 2'd1);
    run_word("w254", 2, 8'd254, 2'd2);
    run_word("wFF", 3, 8'hFF, 2'd0);
    run_word("w0", 3, 8'd0, 2'd0);

    // All four requesting: pointer sits at 3, so order is 0,1,2,3,0
    for (int i = 0; i < 4; i++) words[i] = 8'(i + 3);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("rr", 20, n);
      chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
      if (g > 0) chk($sformatf("rr%0d_gap", g), 32'(n), 32'd2);
      req[g % 4] = 1'b0;
      wait_done("rr", 20, n);
      chk($sformatf("rr%0d_lat", g), 32'(n), 32'd8);
      chk($sformatf("rr%0d_id", g), 32'(done_id), 32'(g % 4));
      chk($sformatf("rr%0d_res", g), 32'(residue), 32'(((g % 4) + 3) % 3));
      req[g % 4] = 1'b1;
    end
    req = 4'd0;
    repeat (2) tick();

    // Request raised mid-SHIFT waits for IDLE
    words[1] = 8'd9;
    words[2] = 8'd10;
    req = 4'b0010;
    wait_gnt("late", 20, n);
    chk("late_gnt1", 32'(gnt), 32'b0010);
    req = 4'd0;
    gnt_or = 0;
    repeat (2) begin tick(); gnt_or = gnt_or | 32'(gnt); end
    req[2] = 1'b1;
    repeat (5) begin tick(); gnt_or = gnt_or | 32'(gnt); end
    chk("late_no_gnt", 32'(gnt_or), 32'd0);
    tick();
    chk("late_done1", 32'(done), 32'd1);
    chk("late_id1", 32'(done_id), 32'd1);
    chk("late_res1", 32'(residue), 32'd0);
    wait_gnt("late2", 20, n);
    chk("late_gap", 32'(n), 32'd2);
    chk("late_gnt2", 32'(gnt), 32'b0100);
    req = 4'd0;
    wait_done("late2", 20, n);
    chk("late_id2", 32'(done_id), 32'd2);
    chk("late_res2", 32'(residue), 32'd1);
    chk("late_div2", 32'(divisible), 32'd0);
    repeat (2) tick();

    // Reset mid-SHIFT aborts and restores the pointer
    words[0] = 8'd5;
    req = 4'b0001;
    tick();
    chk("abort_gnt", 32'(gnt), 32'b0001);
    req = 4'd0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'(residue), 32'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin tick(); done_cnt += 32'(done); end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    words[1] = 8'd11;
    words[3] = 8'd12;
    req = 4'b1010;
    wait_gnt("post", 20, n);
    chk("post_gnt", 32'(gnt), 32'b0010);
    req = 4'd0;
    wait_done("post", 20, n);
    chk("post_id", 32'(done_id), 32'd1);
    chk("post_res", 32'(residue), 32'd2);
    chk("post_div", 32'(divisible), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
